ahb_s2m_mux: RTL



---
 rtl/ahb_pkg.sv | 32 +++
 rtl/ahb_default_slave.sv | 51 +++++
 rtl/ahb_s2m_mux.sv | 67 ++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and widths used across the interconnect.
// Encodings match the AMBA AHB bus definitions.
package ahb_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01,
      RESP_RETRY = 2'b10,
      RESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_t;

   // A transfer only demands a response when it is NONSEQ or SEQ.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// ERROR response, and IDLE/BUSY transfers with a zero-wait OKAY.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       hready_in,
   input  logic       unmapped,
   input  logic [1:0] htrans,
   output logic       hready,
   output logic [1:0] hresp
);

   ds_state_t state_q;
   ds_state_t state_d;
   logic      start;

   assign start = hready_in && unmapped && is_active(htrans);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge HCLK) begin
      if (HRESET) state_q <= DS_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output is given a default before the case so no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      hready  = 1'b1;
      hresp   = RESP_OKAY;
      case (state_q)
         DS_IDLE: begin
            if (start) state_d = DS_ERR1;
         end
         DS_ERR1: begin
            hready  = 1'b0;
            hresp   = RESP_ERROR;
            state_d = DS_ERR2;
         end
         DS_ERR2: begin
            hresp   = RESP_ERROR;
            state_d = start ? DS_ERR1 : DS_IDLE;
         end
         default: state_d = DS_IDLE;
      endcase
   end

endmodule

// File: rtl/ahb_s2m_mux.sv
// Slave-to-master response mux: registers the decoder select at address-phase
// acceptance and routes the owning slave's HRDATA/HREADY/HRESP to the master.
module ahb_s2m_mux
   import ahb_pkg::*;
#(
   parameter int NSLV = 3
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic [NSLV-1:0]          HSEL,
   input  logic                     HSELDEF,
   input  logic [1:0]               HTRANSm,
   input  logic [DATA_W*NSLV-1:0]   HRDATAS,
   input  logic [NSLV-1:0]          HREADYOUTS,
   input  logic [2*NSLV-1:0]        HRESPS,
   output logic [DATA_W-1:0]        HRDATAm,
   output logic                     HREADYm,
   output logic [1:0]               HRESPm
);

   logic [NSLV:0]   dsel;
   logic [NSLV:0]   sel_next;
   logic [NSLV-1:0] sel_low;
   logic            unmapped;
   logic            ds_hready;
   logic [1:0]      ds_hresp;

   // Isolate the lowest set HSEL bit so overlapping decodes resolve to the
   // lowest-numbered slave; the default slave only wins when HSEL is empty.
   assign sel_low  = HSEL & (~HSEL + {{(NSLV-1){1'b0}}, 1'b1});
   assign unmapped = HSELDEF && (HSEL == '0);
   assign sel_next = {unmapped, sel_low};

   always_ff @(posedge HCLK) begin
      if (HRESET)       dsel <= '0;
      else if (HREADYm) dsel <= sel_next;
   end

   ahb_default_slave u_default_slave (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .hready_in (HREADYm),
      .unmapped  (unmapped),
      .htrans    (HTRANSm),
      .hready    (ds_hready),
      .hresp     (ds_hresp)
   );

   // dsel is one-hot or zero, so at most one branch below fires.
   always_comb begin
      HRDATAm = '0;
      HREADYm = 1'b1;
      HRESPm  = RESP_OKAY;
      for (int i = 0; i < NSLV; i++) begin
         if (dsel[i]) begin
            HRDATAm = HRDATAS[DATA_W*i +: DATA_W];
            HREADYm = HREADYOUTS[i];
            HRESPm  = HRESPS[2*i +: 2];
         end
      end
      if (dsel[NSLV]) begin
         HREADYm = ds_hready;
         HRESPm  = ds_hresp;
      end
   end

endmodule
